// File: rtl/tlb_inv_walker_pkg.sv
// tlb_inv_walker_pkg: INVTLB op codes, page sizes, walker states and the per-entry match rule.
package tlb_inv_walker_pkg;
  localparam logic [4:0] INV_ALL0   = 5'd0;
  localparam logic [4:0] INV_ALL1   = 5'd1;
  localparam logic [4:0] INV_G1     = 5'd2;
  localparam logic [4:0] INV_G0     = 5'd3;
  localparam logic [4:0] INV_ASID   = 5'd4;
  localparam logic [4:0] INV_ASIDVA = 5'd5;
  localparam logic [4:0] INV_GASVA  = 5'd6;
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Entries with E=0 never match, so the clear count only reflects real clears.
  function automatic logic inv_match(
    input logic [4:0]  op,
    input logic [9:0]  asid,
    input logic [18:0] vppn,
    input logic        e,
    input logic        g,
    input logic [9:0]  e_asid,
    input logic [18:0] e_vppn,
    input logic [5:0]  e_ps
  );
    logic va, am;
    va = (e_ps == PS_4K) ? (vppn == e_vppn) : (vppn[18:9] == e_vppn[18:9]);
    am = (asid == e_asid);
    return e & ((op == INV_ALL0) | (op == INV_ALL1) |
                ((op == INV_G1) & g) |
                ((op == INV_G0) & !g) |
                ((op == INV_ASID) & !g & am) |
                ((op == INV_ASIDVA) & !g & am & va) |
                ((op == INV_GASVA) & (g | am) & va));
  endfunction
endpackage

// File: rtl/tools.sv
// decoder_4_16: binary index to one-hot decoder.
module decoder_4_16 (
  input  logic [3:0]  i_idx,
  output logic [15:0] o_dec
);
  assign o_dec = 16'd1 << i_idx;
endmodule

// File: rtl/tlb_inv_walker.sv
// tlb_inv_walker: sequential INVTLB engine that walks every TLB entry and
// drives a one-hot clear-enable for each entry matching the latched command.
module tlb_inv_walker
  import tlb_inv_walker_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [9:0]        cmd_asid,
  input  logic [18:0]       cmd_vppn,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_e,
  input  logic              rd_g,
  input  logic [9:0]        rd_asid,
  input  logic [18:0]       rd_vppn,
  input  logic [5:0]        rd_ps,
  output logic [TLBNUM-1:0] inv_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W:0]    inv_cnt
);
  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [4:0]        r_op;
  logic [9:0]        r_asid;
  logic [18:0]       r_vppn;
  logic [IDX_W:0]    r_cnt;
  logic              r_err;
  logic              w_match;
  logic [TLBNUM-1:0] w_dec;

  decoder_4_16 u_dec (
    .i_idx (r_idx),
    .o_dec (w_dec)
  );

  assign w_match   = (r_state == ST_WALK) &
                     inv_match(r_op, r_asid, r_vppn, rd_e, rd_g, rd_asid, rd_vppn, rd_ps);
  assign inv_en    = w_match ? w_dec : '0;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_WALK);
  assign done      = (r_state == ST_DONE);
  assign err       = done & r_err;
  assign inv_cnt   = r_cnt;
  assign rd_idx    = r_idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_op    <= '0;
      r_asid  <= '0;
      r_vppn  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (cmd_valid) begin
        r_op    <= cmd_op;
        r_asid  <= cmd_asid;
        r_vppn  <= cmd_vppn;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_err   <= (cmd_op > INV_GASVA);
        r_state <= (cmd_op > INV_GASVA) ? ST_DONE : ST_WALK;
      end
    end else if (r_state == ST_WALK) begin
      r_cnt <= r_cnt + (IDX_W+1)'(w_match);
      r_idx <= r_idx + 1'b1;
      if (r_idx == IDX_W'(TLBNUM-1)) r_state <= ST_DONE;
    end else begin
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_tlb_inv_walker.sv
// tb_tlb_inv_walker: table-driven directed test of the INVTLB walker against a
// bench-side TLB image with hand-computed clear masks.
module tb_tlb_inv_walker;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_op = '0;
  logic [9:0]  cmd_asid = '0;
  logic [18:0] cmd_vppn = '0;
  logic [3:0]  rd_idx;
  logic        rd_e, rd_g;
  logic [9:0]  rd_asid;
  logic [18:0] rd_vppn;
  logic [5:0]  rd_ps;
  logic [15:0] inv_en;
  logic        busy, done, err;
  logic [4:0]  inv_cnt;

  logic [15:0] m_e, m_g;
  logic [9:0]  m_asid [16];
  logic [18:0] m_vppn [16];
  logic [5:0]  m_ps   [16];

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [15:0] e, g;
    logic [3:0]  i0, i1;
    logic [9:0]  a0, a1;
    logic [18:0] v0, v1;
    logic [5:0]  p0, p1;
    logic [15:0] exp;
    logic [4:0]  cnt;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  always_comb begin
    rd_e    = m_e[rd_idx];
    rd_g    = m_g[rd_idx];
    rd_asid = m_asid[rd_idx];
    rd_vppn = m_vppn[rd_idx];
    rd_ps   = m_ps[rd_idx];
  end

  tlb_inv_walker dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_asid(cmd_asid), .cmd_vppn(cmd_vppn), .rd_idx(rd_idx),
    .rd_e(rd_e), .rd_g(rd_g), .rd_asid(rd_asid), .rd_vppn(rd_vppn), .rd_ps(rd_ps),
    .inv_en(inv_en), .busy(busy), .done(done), .err(err), .inv_cnt(inv_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
    input logic [15:0] e, input logic [15:0] g,
    input logic [3:0] i0, input logic [9:0] a0, input logic [18:0] v0, input logic [5:0] p0,
    input logic [3:0] i1, input logic [9:0] a1, input logic [18:0] v1, input logic [5:0] p1,
    input logic [15:0] exp, input logic [4:0] cnt, input logic er);
    vec_t v;
    v.op = op; v.asid = asid; v.vppn = vppn; v.e = e; v.g = g;
    v.i0 = i0; v.a0 = a0; v.v0 = v0; v.p0 = p0;
    v.i1 = i1; v.a1 = a1; v.v1 = v1; v.p1 = p1;
    v.exp = exp; v.cnt = cnt; v.err = er;
    return v;
  endfunction

  task automatic load(input vec_t v);
    m_e = v.e;
    m_g = v.g;
    for (int i = 0; i < 16; i++) begin
      m_asid[i] = '0; m_vppn[i] = '0; m_ps[i] = 6'd12;
    end
    m_asid[v.i0] = v.a0; m_vppn[v.i0] = v.v0; m_ps[v.i0] = v.p0;
    m_asid[v.i1] = v.a1; m_vppn[v.i1] = v.v1; m_ps[v.i1] = v.p1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic accept(input vec_t v);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_asid = v.asid; cmd_vppn = v.vppn;
    @(negedge clk);
    cmd_op = 5'($urandom); cmd_asid = 10'($urandom); cmd_vppn = 19'($urandom);
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    string t;
    v = vecs[vi];
    t = $sformatf("v%0d", vi);
    load(v);
    wait_ready(t);
    accept(v);
    if (!v.err) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("%s_idx%0d", t, k), 32'(rd_idx), 32'(k));
        chk($sformatf("%s_busy%0d", t, k), 32'(busy), 32'd1);
        chk($sformatf("%s_en%0d", t, k), 32'(inv_en), v.exp[k] ? (32'd1 << k) : 32'd0);
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    chk({t, "_done"}, 32'(done), 32'd1);
    chk({t, "_err"}, 32'(err), 32'(v.err));
    chk({t, "_cnt"}, 32'(inv_cnt), 32'(v.cnt));
    chk({t, "_dbusy"}, 32'(busy), 32'd0);
    chk({t, "_den"}, 32'(inv_en), 32'd0);
    chk({t, "_dready"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk({t, "_idone"}, 32'(done), 32'd0);
    chk({t, "_iready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    //             op    asid     vppn       e        g        i0 a0      v0        p0     i1 a1      v1        p1     exp      cnt  err
    vecs[0] = mk(5'd0, 10'h0,   19'h0,     16'hFFFF, 16'h0000, 0, 10'h0,   19'h0,     6'd12, 0, 10'h0,   19'h0,     6'd12, 16'hFFFF, 16, 0);
    vecs[1] = mk(5'd2, 10'h0,   19'h0,     16'hFFFF, 16'h0208, 0, 10'h0,   19'h0,     6'd12, 0, 10'h0,   19'h0,     6'd12, 16'h0208, 2,  0);
    vecs[2] = mk(5'd5, 10'h2A,  19'h12345, 16'hFFFF, 16'h0000, 5, 10'h2A,  19'h12345, 6'd12, 7, 10'h2A,  19'h12344, 6'd12, 16'h0020, 1,  0);
    vecs[3] = mk(5'd6, 10'h3FF, 19'h40000, 16'hFFEF, 16'h0014, 2, 10'h0,   19'h401FF, 6'd21, 4, 10'h0,   19'h401FF, 6'd21, 16'h0004, 1,  0);
    vecs[4] = mk(5'd7, 10'h0,   19'h0,     16'hFFFF, 16'hFFFF, 0, 10'h0,   19'h0,     6'd12, 0, 10'h0,   19'h0,     6'd12, 16'h0000, 0,  1);
    vecs[5] = mk(5'd3, 10'h0,   19'h0,     16'hFFFE, 16'h00F0, 0, 10'h0,   19'h0,     6'd12, 0, 10'h0,   19'h0,     6'd12, 16'hFF0E, 11, 0);
    vecs[6] = mk(5'd4, 10'h2A,  19'h0,     16'hFFFF, 16'h0040, 5, 10'h2A,  19'h0,     6'd12, 6, 10'h2A,  19'h0,     6'd12, 16'h0020, 1,  0);
    vecs[7] = mk(5'd1, 10'h0,   19'h0,     16'h00FF, 16'h0000, 0, 10'h0,   19'h0,     6'd12, 0, 10'h0,   19'h0,     6'd12, 16'h00FF, 8,  0);
    vecs[8] = mk(5'd5, 10'h2A,  19'h12345, 16'hFFFF, 16'h0000, 10, 10'h2A, 19'h12200, 6'd21, 11, 10'h2A, 19'h12200, 6'd12, 16'h0400, 1,  0);
    vecs[9] = mk(5'd6, 10'h155, 19'h00001, 16'hFFFF, 16'h0000, 15, 10'h155, 19'h00001, 6'd12, 0, 10'h155, 19'h00002, 6'd12, 16'h8000, 1,  0);

    load(vecs[0]);
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_en", 32'(inv_en), 32'd0);
    chk("rst_idx", 32'(rd_idx), 32'd0);
    chk("rst_cnt", 32'(inv_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset mid-walk: outputs must drop without waiting for a clock edge.
    load(vecs[0]);
    wait_ready("mr");
    accept(vecs[0]);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("mr_en%0d", k), 32'(inv_en), 32'd1 << k);
      @(negedge clk);
    end
    chk("mr_en6", 32'(inv_en), 32'h40);
    cmd_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_en", 32'(inv_en), 32'd0);
    chk("mr_idx", 32'(rd_idx), 32'd0);
    chk("mr_cnt", 32'(inv_cnt), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("mr_ready", 32'(cmd_ready), 32'd1);
    run_vec(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
